// File: rtl/plab5_mcore_mem_req_net_serializer.sv
// Request-side bridge from a cache-line memory port to the split control/data network.
// Define PLAB5_MCORE_MEM_NET_DOMAIN_EN to prepend a domain bit (p_net_src%2) to the control payload.
module plab5_mcore_mem_req_net_serializer #(
  parameter int          p_net_src           = 0,
  parameter int          p_num_banks         = 2,
  parameter int          p_dest_mode         = 0,
  parameter logic [31:0] p_inst_bound        = 32'h4000,
  parameter logic [31:0] p_data_bound        = 32'hc000,
  parameter int          p_mem_opaque_nbits  = 8,
  parameter int          p_mem_addr_nbits    = 32,
  parameter int          p_word_nbits        = 32,
  parameter int          p_cacheline_nwords  = 4,
  parameter int          p_net_opaque_nbits  = 4,
  parameter int          p_net_srcdest_nbits = 3,
  localparam int c_len_nbits  = $clog2(p_cacheline_nwords*p_word_nbits/8),
  localparam int c_data_nbits = p_cacheline_nwords*p_word_nbits,
  localparam int c_msg_nbits  = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + c_len_nbits + c_data_nbits,
`ifdef PLAB5_MCORE_MEM_NET_DOMAIN_EN
  localparam int c_dom_nbits  = 1,
`else
  localparam int c_dom_nbits  = 0,
`endif
  localparam int c_pay_nbits  = c_dom_nbits + 3 + p_mem_opaque_nbits + p_mem_addr_nbits + c_len_nbits,
  localparam int c_ctrl_nbits = 2*p_net_srcdest_nbits + p_net_opaque_nbits + c_pay_nbits
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    mem_req_val,
  output logic                    mem_req_rdy,
  input  logic [c_msg_nbits-1:0]  mem_req_msg,
  output logic                    net_ctrl_val,
  input  logic                    net_ctrl_rdy,
  output logic [c_ctrl_nbits-1:0] net_ctrl_msg,
  output logic                    net_data_val,
  input  logic                    net_data_rdy,
  output logic [p_word_nbits-1:0] net_data_msg
);

  // state | meaning
  // IDLE  | ready for a new request
  // CTRL  | presenting the control flit
  // DATA  | presenting data word idx of nf
  typedef enum logic [1:0] {IDLE, CTRL, DATA} state_t;

  localparam int c_ns         = p_net_srcdest_nbits;
  localparam int c_mo         = p_mem_opaque_nbits;
  localparam int c_ma         = p_mem_addr_nbits;
  localparam int c_nf_nbits   = $clog2(p_cacheline_nwords) + 1;
  localparam int c_idx_nbits  = (p_cacheline_nwords > 1) ? $clog2(p_cacheline_nwords) : 1;
  localparam int c_bpw        = p_word_nbits / 8;
  localparam int c_bpw_log2   = $clog2(c_bpw);
  localparam int c_line_lsb   = c_bpw_log2 + $clog2(p_cacheline_nwords);
  localparam int c_bank_nbits = (p_num_banks > 1) ? $clog2(p_num_banks) : 1;

  localparam logic [c_ns-1:0] c_src        = c_ns'(p_net_src);
  localparam logic [c_ma-1:0] c_inst_bound = c_ma'(p_inst_bound);
  localparam logic [c_ma-1:0] c_data_bound = c_ma'(p_data_bound);

  logic [2:0]              req_type;
  logic [c_mo-1:0]         req_opaque;
  logic [c_ma-1:0]         req_addr;
  logic [c_len_nbits-1:0]  req_len;
  logic [c_data_nbits-1:0] req_data;
  logic [c_len_nbits:0]    len_round;
  logic [c_nf_nbits-1:0]   req_nf;
  logic [c_ns-1:0]         req_dest;
  logic [c_ns-1:0]         unused_opaque_hi;

  assign req_type   = mem_req_msg[c_msg_nbits-1 -: 3];
  assign req_opaque = mem_req_msg[c_data_nbits+c_len_nbits+c_ma +: c_mo];
  assign req_addr   = mem_req_msg[c_data_nbits+c_len_nbits +: c_ma];
  assign req_len    = mem_req_msg[c_data_nbits +: c_len_nbits];
  assign req_data   = mem_req_msg[c_data_nbits-1:0];
  assign len_round  = {1'b0, req_len} + (c_len_nbits+1)'(c_bpw - 1);
  // The top ns opaque bits are replaced by the source id.
  assign unused_opaque_hi = req_opaque[c_mo-1 -: c_ns];

  always_comb begin
    req_nf = c_nf_nbits'(1);
    case (req_type)
      3'd0:       req_nf = '0;
      3'd1, 3'd2: req_nf = (req_len == '0) ? c_nf_nbits'(p_cacheline_nwords)
                                           : c_nf_nbits'(len_round >> c_bpw_log2);
      default:    ;
    endcase
  end

  always_comb begin
    req_dest = '0;
    if (p_num_banks > 1) begin
      if (p_dest_mode == 0) begin
        if (mode) req_dest = (req_addr < c_data_bound) ? '0 : c_ns'(1);
        else      req_dest = (req_addr < c_inst_bound) ? '0 : c_ns'(1);
      end else begin
        req_dest = c_ns'(req_addr[c_line_lsb +: c_bank_nbits]);
      end
    end
  end

  state_t                  state_q, state_d;
  logic [c_idx_nbits-1:0]  idx_q, idx_d;
  logic [c_nf_nbits-1:0]   nf_q, nf_d;
  logic [c_ns-1:0]         dest_q, dest_d;
  logic [2:0]              type_q, type_d;
  logic [c_mo-1:0]         opaque_q, opaque_d;
  logic [c_ma-1:0]         addr_q, addr_d;
  logic [c_len_nbits-1:0]  len_q, len_d;
  logic [c_data_nbits-1:0] data_q, data_d;
  logic                    idx_last;

  assign idx_last = (c_nf_nbits'(idx_q) == nf_q - c_nf_nbits'(1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    nf_d         = nf_q;
    dest_d       = dest_q;
    type_d       = type_q;
    opaque_d     = opaque_q;
    addr_d       = addr_q;
    len_d        = len_q;
    data_d       = data_q;
    mem_req_rdy  = 1'b0;
    net_ctrl_val = 1'b0;
    net_data_val = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req_rdy = !reset;
        if (mem_req_val && !reset) begin
          nf_d     = req_nf;
          dest_d   = req_dest;
          type_d   = req_type;
          opaque_d = {c_src, req_opaque[c_mo-c_ns-1:0]};
          addr_d   = req_addr;
          len_d    = req_len;
          data_d   = req_data;
          state_d  = CTRL;
        end
      end
      CTRL: begin
        net_ctrl_val = !reset;
        if (net_ctrl_rdy) state_d = (nf_q != '0) ? DATA : IDLE;
      end
      DATA: begin
        net_data_val = !reset;
        if (net_data_rdy) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + c_idx_nbits'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      nf_q     <= '0;
      dest_q   <= '0;
      type_q   <= '0;
      opaque_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nf_q     <= nf_d;
      dest_q   <= dest_d;
      type_q   <= type_d;
      opaque_q <= opaque_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      data_q   <= data_d;
    end
  end

  logic [c_pay_nbits-1:0]  payload;
  logic [p_word_nbits-1:0] words [p_cacheline_nwords];

`ifdef PLAB5_MCORE_MEM_NET_DOMAIN_EN
  assign payload = {1'(p_net_src % 2), type_q, opaque_q, addr_q, len_q};
`else
  assign payload = {type_q, opaque_q, addr_q, len_q};
`endif

  assign net_ctrl_msg = {dest_q, c_src, {p_net_opaque_nbits{1'b0}}, payload};

  always_comb begin
    for (int i = 0; i < p_cacheline_nwords; i++) words[i] = data_q[i*p_word_nbits +: p_word_nbits];
  end

  assign net_data_msg = words[idx_q];

endmodule

// File: tb/tb_plab5_mcore_mem_req_net_serializer.sv
// Directed vector bench: an interleave-steered and a range-steered instance share all inputs.
module tb_plab5_mcore_mem_req_net_serializer;

  localparam int MO = 8, MA = 32, W = 32, NW = 4, NO = 4, NS = 3, LENW = 4;
  localparam int MSGW = 3 + MO + MA + LENW + NW*W;
`ifdef PLAB5_MCORE_MEM_NET_DOMAIN_EN
  localparam int DOMW = 1;
`else
  localparam int DOMW = 0;
`endif
  localparam int PW = DOMW + 3 + MO + MA + LENW;
  localparam int CW = 2*NS + NO + PW;
  localparam logic [2:0] IL_SRC = 3'd3;
  localparam logic [2:0] RG_SRC = 3'd2;

  logic            clk = 1'b0;
  logic            reset, mode, mem_req_val, net_ctrl_rdy, net_data_rdy;
  logic [MSGW-1:0] mem_req_msg;
  logic            il_req_rdy, il_ctrl_val, il_data_val;
  logic            rg_req_rdy, rg_ctrl_val, rg_data_val;
  logic [CW-1:0]   il_ctrl_msg, rg_ctrl_msg;
  logic [W-1:0]    il_data_msg, rg_data_msg;

  always #5 clk = ~clk;

  plab5_mcore_mem_req_net_serializer #(.p_net_src(3), .p_dest_mode(1)) dut_il (
    .clk(clk), .reset(reset), .mode(mode),
    .mem_req_val(mem_req_val), .mem_req_rdy(il_req_rdy), .mem_req_msg(mem_req_msg),
    .net_ctrl_val(il_ctrl_val), .net_ctrl_rdy(net_ctrl_rdy), .net_ctrl_msg(il_ctrl_msg),
    .net_data_val(il_data_val), .net_data_rdy(net_data_rdy), .net_data_msg(il_data_msg));

  plab5_mcore_mem_req_net_serializer #(.p_net_src(2), .p_dest_mode(0)) dut_rg (
    .clk(clk), .reset(reset), .mode(mode),
    .mem_req_val(mem_req_val), .mem_req_rdy(rg_req_rdy), .mem_req_msg(mem_req_msg),
    .net_ctrl_val(rg_ctrl_val), .net_ctrl_rdy(net_ctrl_rdy), .net_ctrl_msg(rg_ctrl_msg),
    .net_data_val(rg_data_val), .net_data_rdy(net_data_rdy), .net_data_msg(rg_data_msg));

  typedef struct {
    logic [2:0]  typ;
    logic [7:0]  opq;
    logic [31:0] addr;
    logic [3:0]  len;
    logic        md;
    logic [31:0] dbase;
    int          nf;
    logic [2:0]  d_il;
    logic [2:0]  d_rg;
  } vec_t;

  vec_t vecs[11];
  int   errs = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MSGW-1:0] mk_msg(input vec_t v);
    return {v.typ, v.opq, v.addr, v.len, v.dbase + 32'd3, v.dbase + 32'd2, v.dbase + 32'd1, v.dbase};
  endfunction

  function automatic logic [CW-1:0] exp_ctrl(input logic [2:0] dest, input logic [2:0] src, input vec_t v);
    logic [PW-1:0] pl;
`ifdef PLAB5_MCORE_MEM_NET_DOMAIN_EN
    pl = {src[0], v.typ, src, v.opq[4:0], v.addr, v.len};
`else
    pl = {v.typ, src, v.opq[4:0], v.addr, v.len};
`endif
    return {dest, src, 4'b0000, pl};
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int guard;
    guard = 0;
    mem_req_msg = mk_msg(v);
    mode        = v.md;
    mem_req_val = 1'b1;
    while (!il_req_rdy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept_timeout"}, 128'(guard < 20), 128'd1);
    @(negedge clk);
    mem_req_val = 1'b0;
    mem_req_msg = '0;
    mode        = ~v.md;
    chk({tag, "_ctrl_val"}, 128'(il_ctrl_val), 128'd1);
    chk({tag, "_req_rdy_busy"}, 128'(il_req_rdy), 128'd0);
    chk({tag, "_il_ctrl"}, 128'(il_ctrl_msg), 128'(exp_ctrl(v.d_il, IL_SRC, v)));
    chk({tag, "_rg_ctrl"}, 128'(rg_ctrl_msg), 128'(exp_ctrl(v.d_rg, RG_SRC, v)));
    net_ctrl_rdy = 1'b0;
    net_data_rdy = 1'b1;
    @(negedge clk);
    chk({tag, "_ctrl_hold"}, 128'({il_ctrl_val, il_data_val}), 128'(2'b10));
    chk({tag, "_ctrl_msg_hold"}, 128'(il_ctrl_msg), 128'(exp_ctrl(v.d_il, IL_SRC, v)));
    net_ctrl_rdy = 1'b1;
    net_data_rdy = 1'b0;
    @(negedge clk);
    for (int k = 0; k < v.nf; k++) begin
      if (k % 2 == 0) begin
        net_data_rdy = 1'b0;
        @(negedge clk);
        chk({tag, "_data_stall"}, 128'({il_data_val, il_data_msg}), 128'({1'b1, v.dbase + 32'(k)}));
      end
      net_data_rdy = 1'b1;
      chk({tag, "_data_il"}, 128'({il_data_val, il_ctrl_val, il_data_msg}), 128'({2'b10, v.dbase + 32'(k)}));
      chk({tag, "_data_rg"}, 128'({rg_data_val, rg_data_msg}), 128'({1'b1, v.dbase + 32'(k)}));
      @(negedge clk);
      net_data_rdy = 1'b0;
    end
    net_ctrl_rdy = 1'b0;
    chk({tag, "_done_idle"}, 128'({il_data_val, il_ctrl_val, il_req_rdy, rg_req_rdy}), 128'(4'b0011));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            typ   opq    addr          len  md   dbase           nf il    rg
    vecs[0]  = '{3'd0, 8'hAB, 32'h0000_0010, 4'd0,  1'b0, 32'h0,          0, 3'd1, 3'd0};
    vecs[1]  = '{3'd1, 8'h5C, 32'h0000_3ffc, 4'd0,  1'b0, 32'hA0,         4, 3'd1, 3'd0};
    vecs[2]  = '{3'd1, 8'h12, 32'h0000_4000, 4'd6,  1'b0, 32'h1000_0000,  2, 3'd0, 3'd1};
    vecs[3]  = '{3'd0, 8'hFF, 32'h0000_bffc, 4'd0,  1'b1, 32'h0,          0, 3'd1, 3'd0};
    vecs[4]  = '{3'd0, 8'h01, 32'h0000_c000, 4'd0,  1'b1, 32'h0,          0, 3'd0, 3'd1};
    vecs[5]  = '{3'd2, 8'h3E, 32'h0000_0020, 4'd1,  1'b1, 32'h55,         1, 3'd0, 3'd0};
    vecs[6]  = '{3'd3, 8'hE7, 32'h0000_0014, 4'd9,  1'b0, 32'h77,         1, 3'd1, 3'd0};
    vecs[7]  = '{3'd1, 8'h80, 32'hffff_fff0, 4'd15, 1'b1, 32'hDEAD_0000,  4, 3'd1, 3'd1};
    vecs[8]  = '{3'd1, 8'h1F, 32'h0000_0004, 4'd4,  1'b0, 32'h33,         1, 3'd0, 3'd0};
    vecs[9]  = '{3'd0, 8'h44, 32'h0000_8000, 4'd0,  1'b1, 32'h0,          0, 3'd0, 3'd0};
    vecs[10] = '{3'd0, 8'h44, 32'h0000_8000, 4'd0,  1'b0, 32'h0,          0, 3'd0, 3'd1};

    reset = 1'b1; mode = 1'b0; mem_req_val = 1'b1; net_ctrl_rdy = 1'b1; net_data_rdy = 1'b1;
    mem_req_msg = mk_msg(vecs[1]);
    repeat (3) @(negedge clk);
    chk("rst_outputs", 128'({il_req_rdy, il_ctrl_val, il_data_val, rg_req_rdy}), 128'(4'b0000));
    chk("rst_fields", 128'({il_data_msg, il_ctrl_msg[LENW +: MA]}), 128'(0));
    mem_req_val = 1'b0; net_ctrl_rdy = 1'b0; net_data_rdy = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_release_rdy", 128'({il_req_rdy, il_ctrl_val}), 128'(2'b10));

    // Back-to-back read with the control channel always ready.
    @(negedge clk);
    net_ctrl_rdy = 1'b1;
    mem_req_msg  = mk_msg(vecs[0]);
    mode         = 1'b0;
    mem_req_val  = 1'b1;
    chk("rd_acc_rdy", 128'(il_req_rdy), 128'd1);
    @(negedge clk);
    mem_req_val = 1'b0;
    chk("rd_ctrl_next", 128'({il_ctrl_val, il_req_rdy}), 128'(2'b10));
    chk("rd_ctrl_msg", 128'(il_ctrl_msg), 128'(exp_ctrl(3'd1, IL_SRC, vecs[0])));
    @(negedge clk);
    chk("rd_rdy_2cyc", 128'({il_req_rdy, il_ctrl_val, il_data_val}), 128'(3'b100));
    net_ctrl_rdy = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while the second write data flit is being presented.
    @(negedge clk);
    mem_req_msg = mk_msg(vecs[1]);
    mode        = 1'b0;
    mem_req_val = 1'b1;
    @(negedge clk);
    mem_req_val  = 1'b0;
    net_ctrl_rdy = 1'b1;
    @(negedge clk);
    net_ctrl_rdy = 1'b0;
    net_data_rdy = 1'b1;
    chk("rst_flit0", 128'({il_data_val, il_data_msg}), 128'({1'b1, 32'hA0}));
    @(negedge clk);
    chk("rst_flit1", 128'({il_data_val, il_data_msg}), 128'({1'b1, 32'hA1}));
    reset        = 1'b1;
    net_data_rdy = 1'b0;
    #1;
    chk("rst_mid_val", 128'({il_data_val, il_req_rdy, rg_data_val}), 128'(3'b000));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_abort_idle", 128'({il_data_val, il_ctrl_val, il_req_rdy}), 128'(3'b001));
    @(negedge clk);
    run_vec(vecs[0], "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
